// File: rtl/rng_arb.sv
// Two-requester round-robin arbiter in front of a shared RNG FIFO.
// Grants carry a burst limit for preemption and a one-cycle dead SWITCH state between owners.
module rng_arb #(
    parameter int RNG_DAT_W = 64,
    parameter int BURST_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BURST_W-1:0]   burst_max,
    input  logic [1:0]           req,
    input  logic [1:0]           rel,
    input  logic [1:0]           rd_in,
    input  logic [1:0]           rng_start_in0,
    input  logic [1:0]           rng_start_in1,
    input  logic                 fifo_rng_empty,
    input  logic [RNG_DAT_W-1:0] fifo_rng_din,
    output logic                 fifo_rng_rd,
    output logic [1:0]           empty_out,
    output logic [RNG_DAT_W-1:0] dout,
    output logic [1:0]           rng_start,
    output logic [1:0]           gnt,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, GRANT, SWITCH} state_t;

    state_t             state, state_nxt;
    logic               g_idx, g_idx_nxt;
    logic               last_gnt, last_gnt_nxt;
    logic [BURST_W-1:0] cnt, cnt_nxt;
    logic [1:0]         gnt_nxt;
    logic               granted, cnt_hit, winner;

    // Datapath steering: only the owner sees the real empty flag and may read.
    always_comb begin
        granted     = (state == GRANT);
        fifo_rng_rd = granted & rd_in[g_idx] & ~fifo_rng_empty & ~rst;
        empty_out   = 2'b11;
        if (granted) begin
            empty_out[g_idx] = fifo_rng_empty;
        end
        dout    = fifo_rng_din;
        cnt_hit = (burst_max != '0) && (cnt == burst_max);
        winner  = (req == 2'b11) ? ~last_gnt : req[1];
    end

    always_comb begin
        state_nxt    = state;
        g_idx_nxt    = g_idx;
        last_gnt_nxt = last_gnt;
        cnt_nxt      = cnt;
        gnt_nxt      = 2'b00;
        if (fifo_rng_rd && (cnt != '1)) begin
            cnt_nxt = cnt + 1'b1;
        end
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt    = GRANT;
                    g_idx_nxt    = winner;
                    last_gnt_nxt = winner;
                    cnt_nxt      = '0;
                end
            end
            GRANT: begin
                if (rel[g_idx] || !req[g_idx] || (cnt_hit && req[~g_idx])) begin
                    state_nxt = SWITCH;
                end else if (cnt_hit) begin
                    // Burst limit reached with no contender: restart the burst, counting this cycle's read.
                    cnt_nxt    = '0;
                    cnt_nxt[0] = fifo_rng_rd;
                end
            end
            SWITCH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == GRANT) begin
            gnt_nxt[g_idx_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            g_idx     <= 1'b0;
            last_gnt  <= 1'b1;
            cnt       <= '0;
            gnt       <= 2'b00;
            rng_start <= 2'b00;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            g_idx     <= g_idx_nxt;
            last_gnt  <= last_gnt_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            rng_start <= granted ? (g_idx ? rng_start_in1 : rng_start_in0) : 2'b00;
            if ((rd_in & ~gnt) != 2'b00) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/rng_arb.md
RNG_ARB -- requirements
Module: rng_arb

Interface
REQ-001 Parameter RNG_DAT_W, default 64: width of the RNG FIFO data word.
REQ-002 Parameter BURST_W, default 8: width of the burst limit and burst counter.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-005 Port burst_max, input, BURST_W: words per grant before preemption; 0 disables preemption.
REQ-006 Port req, input, 2: per-requester request level; bit i belongs to requester i.
REQ-007 Port rel, input, 2: per-requester release pulse; ends the requester's grant.
REQ-008 Port rd_in, input, 2: per-requester FIFO read strobe.
REQ-009 Port rng_start_in0 / rng_start_in1, input, 2 each: per-requester RNG command (0 idle, 1 run, 2 reseed).
REQ-010 Port fifo_rng_empty, input, 1: shared RNG FIFO empty flag.
REQ-011 Port fifo_rng_din, input, RNG_DAT_W: shared RNG FIFO read data.
REQ-012 Port fifo_rng_rd, output, 1: read strobe to the shared FIFO.
REQ-013 Port empty_out, output, 2: per-requester view of the FIFO empty flag.
REQ-014 Port dout, output, RNG_DAT_W: FIFO data broadcast to both requesters.
REQ-015 Port rng_start, output, 2: command to the outer RNG.
REQ-016 Port gnt, output, 2: one-hot-or-zero grant, registered.
REQ-017 Port err, output, 1: sticky protocol-error flag.

Function
REQ-018 FSM states SHALL be IDLE, GRANT and SWITCH; reset state is IDLE.
REQ-019 In IDLE with req!=0, the FSM SHALL select a winner by round-robin: the requester other than last_gnt wins a tie, and last_gnt resets to 1 so requester 0 wins the first tie.
REQ-020 On the transition IDLE->GRANT, gnt SHALL assert one cycle after req is sampled; the burst counter SHALL clear and last_gnt SHALL update to the winner.
REQ-021 In GRANT, fifo_rng_rd SHALL equal rd_in[g] & ~fifo_rng_empty combinationally, where g is the granted index.
REQ-022 empty_out[g] SHALL equal fifo_rng_empty; empty_out of the non-granted requester, and of both requesters outside GRANT, SHALL be 1.
REQ-023 dout SHALL equal fifo_rng_din combinationally at all times.
REQ-024 The burst counter SHALL increment on each cycle with fifo_rng_rd=1 and SHALL saturate at all-ones.
REQ-025 GRANT->SWITCH SHALL occur on rel[g]=1, or on req[g]=0, or when (counter==burst_max, burst_max!=0, and the other requester's req=1).
REQ-026 When counter==burst_max, burst_max!=0 and the other requester is idle, the grant SHALL be kept and the counter cleared.
REQ-027 SWITCH SHALL last exactly one cycle with gnt=0 and fifo_rng_rd=0, then go to IDLE; this dead cycle lets the outgoing requester drain its pipeline.
REQ-028 rng_start SHALL be registered: rng_start_in of requester g while in GRANT, and 0 otherwise.
REQ-029 rel and a preemption condition in the same cycle SHALL count as a single switch.
REQ-030 rd_in asserted by a requester with no grant SHALL be ignored (no FIFO read) and SHALL set err; err clears only on reset.
REQ-031 rd_in[g] while fifo_rng_empty=1 SHALL NOT read the FIFO and SHALL NOT increment the counter; this is not an error.

Reset
REQ-032 With rst=1 at a clock edge, the block SHALL reach the following on that edge: state=IDLE, gnt=0, rng_start=0, err=0, counter=0, last_gnt=1.
REQ-033 Reset mid-grant SHALL drop gnt on the next edge with no SWITCH cycle; fifo_rng_rd SHALL be 0 while rst=1.

Verification
REQ-034 Single requester: req=01, FIFO non-empty, rd_in[0] held, burst_max=4 -> gnt=01 continuously and 1 FIFO read per cycle; no switch occurs after 4 reads.
REQ-035 Contention: req=11 from reset, burst_max=4 -> gnt sequence 01 for 4 reads, 00 for 1 cycle (SWITCH), 00 in IDLE, then 10 for 4 reads, then back to 01.
REQ-036 Release: requester 1 granted, rel=10 pulse after 3 reads -> SWITCH next cycle; requester 0 is granted if requesting; counter restarts at 0.
REQ-037 Empty FIFO: granted requester 0 with fifo_rng_empty=1 -> empty_out=11, fifo_rng_rd=0, counter frozen; empty_out[0] follows the flag once it deasserts.
REQ-038 Error and reset: rd_in=10 while gnt=01 -> no read and err=1; apply rst=1 while gnt=01 -> gnt=00, err=0, rng_start=00 on the next edge.
